// File: rtl/vga_draw_pkg.sv
// Shared constants for the frame-buffer drawing engine: register map, opcodes,
// frame geometry defaults, FSM state encoding and STATUS bit positions.
package vga_draw_pkg;

  localparam logic [2:0] REG_X0     = 3'd0;
  localparam logic [2:0] REG_Y0     = 3'd1;
  localparam logic [2:0] REG_X1     = 3'd2;
  localparam logic [2:0] REG_Y1     = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam int         NUM_REGS   = 6;

  localparam logic [1:0] OP_PLOT  = 2'b00;
  localparam logic [1:0] OP_FILL  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  localparam int CTRL_GO    = 7;
  localparam int CTRL_VALUE = 0;

  localparam int FB_WIDTH_DEF  = 160;
  localparam int FB_HEIGHT_DEF = 120;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_DRAW  = 3'd2;
  localparam state_t ST_READ  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_PIX  = 2;
  localparam int STAT_ERR  = 3;

  function automatic logic [7:0] clamp_x(input logic [7:0] v, input logic [7:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  function automatic logic [6:0] clamp_y(input logic [7:0] v, input logic [6:0] max_v);
    return (v > {1'b0, max_v}) ? max_v : v[6:0];
  endfunction

endpackage

// File: rtl/vga_draw_if.sv
// Frame-buffer port A: the engine (master) drives address/data/write enable,
// the RAM (slave) returns read data one cycle after the address.
interface vga_draw_if;
  logic [14:0] FB_ADDR;
  logic        FB_DATA_IN;
  logic        FB_WE;
  logic        FB_DATA_OUT;

  modport master (output FB_ADDR, FB_DATA_IN, FB_WE, input FB_DATA_OUT);
  modport slave  (input FB_ADDR, FB_DATA_IN, FB_WE, output FB_DATA_OUT);
endinterface

// File: rtl/vga_draw_regs.sv
// Bus-side register file: address decode, coordinate/CTRL registers, sticky
// STATUS flags with clear-on-read, and the registered tristate read path.
module vga_draw_regs
  import vga_draw_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hC0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus_addr,
  inout  wire  [7:0] bus_data,
  input  logic       bus_we,
  input  logic       busy,
  input  logic       set_done,
  input  logic       set_err,
  input  logic       pix_load,
  input  logic       pix_val,
  output logic       go,
  output logic [1:0] go_op,
  output logic       go_value,
  output logic [7:0] x0,
  output logic [7:0] y0,
  output logic [7:0] x1,
  output logic [7:0] y1
);

  logic [7:0] off;
  logic       hit, wr, rd, rd_stat;
  logic [2:0] ctrl_q;
  logic       done_q, err_q, pix_q;
  logic       rd_oe;
  logic [7:0] rd_q, rd_mux, status;

  assign off     = bus_addr - BASE_ADDR;
  assign hit     = off < 8'(NUM_REGS);
  assign wr      = hit & bus_we;
  assign rd      = hit & ~bus_we;
  assign rd_stat = rd && (off[2:0] == REG_STATUS);

  assign go       = wr && (off[2:0] == REG_CTRL) && bus_data[CTRL_GO];
  assign go_op    = bus_data[6:5];
  assign go_value = bus_data[CTRL_VALUE];

  always_comb begin
    status = '0;
    status[STAT_BUSY] = busy;
    status[STAT_DONE] = done_q;
    status[STAT_PIX]  = pix_q;
    status[STAT_ERR]  = err_q;
  end

  always_comb begin
    rd_mux = '0;
    case (off[2:0])
      REG_X0:     rd_mux = x0;
      REG_Y0:     rd_mux = y0;
      REG_X1:     rd_mux = x1;
      REG_Y1:     rd_mux = y1;
      REG_CTRL:   rd_mux = {1'b0, ctrl_q[2:1], 4'b0000, ctrl_q[0]};
      REG_STATUS: rd_mux = status;
      default:    rd_mux = '0;
    endcase
  end

  // A flag being set in the same cycle as a STATUS read wins over the clear,
  // so no completion is lost; the read itself returns the pre-clear value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0 <= '0; y0 <= '0; x1 <= '0; y1 <= '0;
      ctrl_q <= '0;
      done_q <= 1'b0; err_q <= 1'b0; pix_q <= 1'b0;
      rd_oe  <= 1'b0; rd_q  <= '0;
    end else begin
      if (wr) begin
        case (off[2:0])
          REG_X0:   x0 <= bus_data;
          REG_Y0:   y0 <= bus_data;
          REG_X1:   x1 <= bus_data;
          REG_Y1:   y1 <= bus_data;
          REG_CTRL: ctrl_q <= {bus_data[6:5], bus_data[CTRL_VALUE]};
          default:  ;
        endcase
      end
      rd_oe  <= rd;
      rd_q   <= rd ? rd_mux : 8'h00;
      done_q <= set_done | (done_q & ~rd_stat);
      err_q  <= set_err | (go & busy) | (err_q & ~rd_stat);
      if (pix_load) pix_q <= pix_val;
    end
  end

  assign bus_data = rd_oe ? rd_q : 8'bz;

endmodule

// File: rtl/vga_draw_engine.sv
// Drawing engine owning frame-buffer port A: plot, rectangle fill, clear and
// (with VGA_DRAW_READBACK_EN defined) single-pixel readback, one write per clock.
module vga_draw_engine
  import vga_draw_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hC0,
  parameter int         FB_WIDTH  = FB_WIDTH_DEF,
  parameter int         FB_HEIGHT = FB_HEIGHT_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  vga_draw_if.master fb,
  output logic       BUSY,
  output logic       DONE_IRQ,
  output state_t     DBG_STATE
);

  // Bus protocol: a write is any cycle with BUS_WE high and an address hit,
  // taken at the clock edge; a read is an address hit with BUS_WE low, and the
  // register value is driven onto BUS_DATA for exactly the following cycle.
  localparam logic [7:0] X_MAX  = 8'(FB_WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(FB_HEIGHT - 1);

  logic       go, go_value;
  logic [1:0] go_op;
  logic [7:0] reg_x0, reg_y0, reg_x1, reg_y1;
  logic       set_err, pix_load, pix_val;

  state_t     state;
  logic [1:0] op_q;
  logic       value_q;
  logic [7:0] bx0, bx1, cx, lx0, lx1;
  logic [6:0] by0, by1, cy, ly0, ly1;
  logic       accept, err_cond;

  vga_draw_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .clk(CLK), .rst(RESET),
    .bus_addr(BUS_ADDR), .bus_data(BUS_DATA), .bus_we(BUS_WE),
    .busy(BUSY), .set_done(DONE_IRQ), .set_err(set_err),
    .pix_load(pix_load), .pix_val(pix_val),
    .go(go), .go_op(go_op), .go_value(go_value),
    .x0(reg_x0), .y0(reg_y0), .x1(reg_x1), .y1(reg_y1)
  );

  // Bounds are resolved per opcode at GO so DRAW only walks a rectangle.
  always_comb begin
    lx0 = clamp_x(reg_x0, X_MAX);
    lx1 = clamp_x(reg_x1, X_MAX);
    ly0 = clamp_y(reg_y0, Y_LAST);
    ly1 = clamp_y(reg_y1, Y_LAST);
    if (go_op == OP_CLEAR) begin
      lx0 = 8'd0;  lx1 = X_MAX;
      ly0 = 7'd0;  ly1 = Y_LAST;
    end else if (go_op != OP_FILL) begin
      lx1 = lx0;
      ly1 = ly0;
    end
  end

  always_comb begin
    err_cond = (op_q == OP_FILL) && ((bx0 > bx1) || (by0 > by1));
`ifndef VGA_DRAW_READBACK_EN
    if (op_q == OP_READ) err_cond = 1'b1;
`endif
  end

  assign accept = go && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      op_q <= '0; value_q <= 1'b0;
      bx0 <= '0; bx1 <= '0; by0 <= '0; by1 <= '0; cx <= '0; cy <= '0;
      fb.FB_ADDR <= '0; fb.FB_DATA_IN <= 1'b0; fb.FB_WE <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= go_op; value_q <= go_value;
        bx0 <= lx0; bx1 <= lx1; by0 <= ly0; by1 <= ly1;
      end
      case (state)
        ST_IDLE:  if (go) state <= ST_SETUP;
        ST_SETUP: begin
          if (err_cond) state <= ST_DONE;
`ifdef VGA_DRAW_READBACK_EN
          else if (op_q == OP_READ) begin
            fb.FB_ADDR <= {by0, bx0};
            fb.FB_WE   <= 1'b0;
            state      <= ST_READ;
          end
`endif
          else begin
            fb.FB_ADDR    <= {by0, bx0};
            fb.FB_DATA_IN <= value_q;
            fb.FB_WE      <= 1'b1;
            cx            <= bx0;
            cy            <= by0;
            state         <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if ((cx == bx1) && (cy == by1)) begin
            fb.FB_WE <= 1'b0;
            state    <= ST_DONE;
          end else if (cx == bx1) begin
            cx         <= bx0;
            cy         <= cy + 7'd1;
            fb.FB_ADDR <= {cy + 7'd1, bx0};
          end else begin
            cx         <= cx + 8'd1;
            fb.FB_ADDR <= {cy, cx + 8'd1};
          end
        end
        ST_READ:  state <= ST_DONE;
        ST_DONE:  state <= go ? ST_SETUP : ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY      = (state == ST_SETUP) || (state == ST_DRAW) || (state == ST_READ);
  assign DONE_IRQ  = (state == ST_DONE);
  assign set_err   = (state == ST_SETUP) && err_cond;
  assign DBG_STATE = state;

  // Readback data for the address driven in READ is valid during DONE.
`ifdef VGA_DRAW_READBACK_EN
  assign pix_load = (state == ST_DONE) && (op_q == OP_READ);
  assign pix_val  = fb.FB_DATA_OUT;
`else
  logic unused_fb_rd;
  assign pix_load     = 1'b0;
  assign pix_val      = 1'b0;
  assign unused_fb_rd = fb.FB_DATA_OUT;
`endif

endmodule

// File: tb/tb_vga_draw_engine.sv
// Bench for vga_draw_engine: directed and random commands against a
// pixel-list reference model, with a scoreboard monitor for FB writes, IRQs, BUSY and bus reads.
module tb_vga_draw_engine;
  import vga_draw_pkg::*;

  localparam logic [7:0] BASE = 8'hC0;

  logic       CLK, RESET, BUS_WE, BUSY, DONE_IRQ, drv_oe;
  logic [7:0] BUS_ADDR, drv_data;
  wire  [7:0] BUS_DATA;
  state_t     DBG_STATE;

  assign BUS_DATA = drv_oe ? drv_data : 8'bz;

  vga_draw_if fb();

  vga_draw_engine #(.BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA),
    .BUS_WE(BUS_WE), .fb(fb), .BUSY(BUSY), .DONE_IRQ(DONE_IRQ), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset / frame-buffer RAM ----------------
  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic ram [0:32767];
  always @(posedge CLK) begin
    if (fb.FB_WE) ram[fb.FB_ADDR] <= fb.FB_DATA_IN;
    fb.FB_DATA_OUT <= ram[fb.FB_ADDR];
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];   // {cycle, fb addr, pixel}
  logic [31:0] irq_q[$];   // cycle of DONE_IRQ
  logic [31:0] busy_q[$];  // BUSY run length in cycles
  logic [39:0] rd_q[$];    // {cycle, bus read data}

  bit         model_fb [0:32767];
  bit         m_done, m_err, m_pix;
  logic [7:0] m_x0, m_y0, m_x1, m_y1;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clampi(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // ---------------- monitor ----------------
  int busy_run = 0;
  always @(negedge CLK) begin
    if (RESET) begin
      exp_q.delete(); irq_q.delete(); busy_q.delete(); rd_q.delete();
      busy_run = 0;
    end else begin
      if (fb.FB_WE) begin
        if (exp_q.size() == 0) check("unexpected_write", {32'(cyc), fb.FB_ADDR, fb.FB_DATA_IN}, 48'hFFFF_FFFF_FFFF);
        else check("fb_write", {32'(cyc), fb.FB_ADDR, fb.FB_DATA_IN}, exp_q.pop_front());
      end
      if (DONE_IRQ) begin
        if (irq_q.size() == 0) check("unexpected_irq", 48'(cyc), 48'hFFFF_FFFF_FFFF);
        else check("done_irq_cycle", 48'(cyc), 48'(irq_q.pop_front()));
      end
      if (BUSY) busy_run++;
      else if (busy_run > 0) begin
        if (busy_q.size() == 0) check("unexpected_busy", 48'(busy_run), 48'hFFFF_FFFF_FFFF);
        else check("busy_length", 48'(busy_run), 48'(busy_q.pop_front()));
        busy_run = 0;
      end
      if (rd_q.size() != 0 && rd_q[0][39:8] == 32'(cyc))
        check("bus_read", 48'(BUS_DATA), 48'(rd_q.pop_front() & 40'hFF));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    BUS_ADDR = 8'h00; BUS_WE = 1'b0; drv_oe = 1'b0; drv_data = 8'h00;
  endtask

  task automatic write_reg(input logic [2:0] off, input logic [7:0] d);
    @(negedge CLK);
    BUS_ADDR = BASE + {5'b0, off}; BUS_WE = 1'b1; drv_data = d; drv_oe = 1'b1;
    case (off)
      REG_X0: m_x0 = d;
      REG_Y0: m_y0 = d;
      REG_X1: m_x1 = d;
      REG_Y1: m_y1 = d;
      default: ;
    endcase
    @(negedge CLK);
    bus_idle();
  endtask

  task automatic bus_read(input logic [2:0] off, input logic [7:0] exp);
    @(negedge CLK);
    BUS_ADDR = BASE + {5'b0, off}; BUS_WE = 1'b0; drv_oe = 1'b0;
    rd_q.push_back({32'(cyc + 1), exp});
    if (off == REG_STATUS) begin m_done = 0; m_err = 0; end
    @(negedge CLK);
    bus_idle();
  endtask

  task automatic read_status();
    bus_read(REG_STATUS, {4'b0, m_err, m_pix, m_done, 1'b0});
  endtask

  // Writes CTRL and, unless the engine is busy, predicts every resulting event.
  task automatic issue_go(input logic [7:0] ctrl, input bit while_busy);
    int g, xa, xb, ya, yb, n;
    logic [1:0] op;
    bit v, bad;
    @(negedge CLK);
    g = cyc;
    BUS_ADDR = BASE + 8'(REG_CTRL); BUS_WE = 1'b1; drv_data = ctrl; drv_oe = 1'b1;
    op = ctrl[6:5]; v = ctrl[0];
    if (while_busy) m_err = 1;
    else begin
      xa = clampi(int'(m_x0), 159); xb = clampi(int'(m_x1), 159);
      ya = clampi(int'(m_y0), 119); yb = clampi(int'(m_y1), 119);
      bad = 0;
      case (op)
        OP_PLOT:  begin xb = xa; yb = ya; end
        OP_FILL:  bad = (xa > xb) || (ya > yb);
        OP_CLEAR: begin xa = 0; xb = 159; ya = 0; yb = 119; end
        default: begin
`ifdef VGA_DRAW_READBACK_EN
          bad = 0;
`else
          bad = 1;
`endif
        end
      endcase
      m_done = 1;
      if (bad) begin
        m_err = 1;
        irq_q.push_back(32'(g + 2)); busy_q.push_back(32'd1);
      end else if (op == OP_READ) begin
        m_pix = model_fb[ya * 256 + xa];
        irq_q.push_back(32'(g + 3)); busy_q.push_back(32'd2);
      end else begin
        n = 0;
        for (int y = ya; y <= yb; y++)
          for (int x = xa; x <= xb; x++) begin
            exp_q.push_back({32'(g + 2 + n), 15'(y * 256 + x), v});
            model_fb[y * 256 + x] = v;
            n++;
          end
        irq_q.push_back(32'(g + 2 + n)); busy_q.push_back(32'(n + 1));
      end
    end
    @(negedge CLK);
    bus_idle();
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit drained = 0;
    for (int i = 0; i < budget && !drained; i++) begin
      @(negedge CLK);
      drained = (exp_q.size() == 0) && (irq_q.size() == 0) && (busy_q.size() == 0) && (rd_q.size() == 0);
    end
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL %s_timeout: pending writes=%0d irqs=%0d busy=%0d reads=%0d required 0",
               name, exp_q.size(), irq_q.size(), busy_q.size(), rd_q.size());
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic run_cmd(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] x1,
                         input logic [7:0] y1, input logic [7:0] ctrl, input string name);
    write_reg(REG_X0, x0); write_reg(REG_Y0, y0);
    write_reg(REG_X1, x1); write_reg(REG_Y1, y1);
    issue_go(ctrl, 0);
    wait_idle(25000, name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b1;
    bus_idle();
    m_done = 0; m_err = 0; m_pix = 0;
    m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0;
    #25;
    check("reset_fb_we", 48'(fb.FB_WE), 48'd0);
    check("reset_fb_addr", 48'(fb.FB_ADDR), 48'd0);
    check("reset_fb_data", 48'(fb.FB_DATA_IN), 48'd0);
    check("reset_busy", 48'(BUSY), 48'd0);
    check("reset_irq", 48'(DONE_IRQ), 48'd0);
    @(negedge CLK); #3 RESET = 1'b0;
    repeat (2) @(negedge CLK);
    read_status();
    bus_read(REG_X0, 8'h00);

    // plot (5,3) value 1, then sticky DONE and its clear
    run_cmd(8'd5, 8'd3, 8'd0, 8'd0, 8'h81, "plot");
    read_status();
    read_status();

    // fill with X1 beyond the right edge
    run_cmd(8'd158, 8'd10, 8'd200, 8'd11, 8'hA0, "fill_clamp");
    read_status();
    read_status();
    bus_read(REG_X1, 8'd200);

    // inverted fill: no writes, ERR
    run_cmd(8'd10, 8'd0, 8'd9, 8'd0, 8'hA1, "fill_err");
    read_status();
    read_status();

    // readback of a set and a cleared pixel
    run_cmd(8'd7, 8'd7, 8'd0, 8'd0, 8'h81, "plot77");
    run_cmd(8'd7, 8'd7, 8'd0, 8'd0, 8'hE0, "read77_one");
    read_status();
    run_cmd(8'd7, 8'd7, 8'd0, 8'd0, 8'h80, "plot77_zero");
    run_cmd(8'd7, 8'd7, 8'd0, 8'd0, 8'hE0, "read77_zero");
    read_status();

    // clear to 1 with a rejected GO in the middle of it
    write_reg(REG_X0, 8'd3);
    issue_go(8'hC1, 0);
    repeat (100) @(negedge CLK);
    issue_go(8'h81, 1);
    wait_idle(25000, "clear");
    read_status();
    read_status();

    // random plots, fills and readbacks on a fully known frame
    for (int i = 0; i < 40; i++) begin
      int sel, x0, y0;
      logic [7:0] ctrl;
      sel = $urandom_range(0, 9);
      x0 = $urandom_range(0, 175);
      y0 = $urandom_range(0, 130);
      ctrl = {1'b1, 2'b00, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))};
      if (sel < 4) ctrl[6:5] = OP_PLOT;
      else if (sel < 9) ctrl[6:5] = OP_FILL;
      else ctrl[6:5] = OP_READ;
      run_cmd(8'(x0), 8'(y0), 8'(x0 + $urandom_range(0, 6) - 1),
              8'(y0 + $urandom_range(0, 5) - 1), ctrl, "random");
      read_status();
      if (i % 8 == 0) bus_read(REG_Y1, m_y1);
    end

    // reset in the middle of a 400-pixel fill
    write_reg(REG_X0, 8'd0);  write_reg(REG_Y0, 8'd50);
    write_reg(REG_X1, 8'd39); write_reg(REG_Y1, 8'd59);
    issue_go(8'hA1, 0);
    repeat (30) @(negedge CLK);
    @(posedge CLK);
    #3 RESET = 1'b1;
    #1;
    check("midreset_fb_we", 48'(fb.FB_WE), 48'd0);
    check("midreset_busy", 48'(BUSY), 48'd0);
    check("midreset_fb_addr", 48'(fb.FB_ADDR), 48'd0);
    check("midreset_state", 48'(DBG_STATE), 48'(ST_IDLE));
    repeat (2) @(negedge CLK);
    #3 RESET = 1'b0;
    m_done = 0; m_err = 0; m_pix = 0;
    m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0;
    repeat (50) @(negedge CLK);
    read_status();
    bus_read(REG_X1, 8'h00);
    wait_idle(100, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
